// File: rtl/envelope_averager_pkg.sv
// Shared definitions for the envelope chain (rectifier, averager, output stages).
//   state_e     : stream FSM states shared by the streaming stages
//   DefaultN    : default sample width
//   DefaultLogW : default log2 of the averaging window
//   sum_w()     : accumulator width needed for a 2^log_w-point sum of n-bit samples
package envelope_averager_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultN    = 16;
  localparam int unsigned DefaultLogW = 3;

  // A sum of 2^log_w unsigned n-bit values never needs more than n+log_w bits.
  function automatic int unsigned sum_w(input int unsigned n, input int unsigned log_w);
    return n + log_w;
  endfunction

  localparam int unsigned DefaultSumW = sum_w(DefaultN, DefaultLogW);

endpackage

// File: rtl/envelope_averager_sample_ring.sv
// W x N sample ring for the moving-average window.
//   clk, rst_n : clock and asynchronous active-low reset (reset zeroes every entry)
//   ptr_i      : entry addressed for both read and write
//   wr_en_i    : write wr_data_i into ring[ptr_i] at the clock edge
//   clr_en_i   : write zero into ring[ptr_i] (clear sweep); wins over wr_en_i
//   wr_data_i  : sample to store
//   rd_data_o  : current contents of ring[ptr_i] (read-before-write: the value evicted
//                by a write in the same cycle)
module envelope_averager_sample_ring #(
  parameter int unsigned N     = 16,
  parameter int unsigned LOG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LOG_W-1:0] ptr_i,
  input  logic             wr_en_i,
  input  logic             clr_en_i,
  input  logic [N-1:0]     wr_data_i,
  output logic [N-1:0]     rd_data_o
);

  localparam int unsigned W = 1 << LOG_W;

  logic [N-1:0] ring_q [W];
  logic [N-1:0] ring_d [W];

  always_comb begin
    ring_d = ring_q;
    if (clr_en_i) begin
      ring_d[ptr_i] = '0;
    end else if (wr_en_i) begin
      ring_d[ptr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(W); i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      ring_q <= ring_d;
    end
  end

  assign rd_data_o = ring_q[ptr_i];

endmodule

// File: rtl/envelope_averager.sv
// 2^LOG_W-point moving average of rectified magnitude samples.
//   clk, rst_n : clock and asynchronous active-low reset
//   ready      : upstream sample valid this cycle
//   in_data    : unsigned rectified sample
//   stop       : upstream end-of-stream marker
//   avg_data   : moving-average result (truncated, no rounding)
//   send_data  : one-cycle pulse, avg_data valid; only once the window is full
//   fill_level : samples currently in the window (0..W)
//   done       : end of stream acknowledged; high for the whole DONE state
// A result appears one edge after the accept that produced it. After stop the ring is
// cleared by a W-cycle pointer sweep; ready during the sweep is ignored.
module envelope_averager
  import envelope_averager_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned LOG_W = DefaultLogW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ready,
  input  logic [N-1:0]   in_data,
  input  logic           stop,
  output logic [N-1:0]   avg_data,
  output logic           send_data,
  output logic [LOG_W:0] fill_level,
  output logic           done
);

  localparam int unsigned SumW = sum_w(N, LOG_W);
  // W expressed in fill/sweep counter width.
  localparam logic [LOG_W:0] FillMax = {1'b1, {LOG_W{1'b0}}};

  state_e           state_q, state_d;
  logic [SumW-1:0]  sum_q, sum_d;
  logic [LOG_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_W:0]   fill_q, fill_d;
  logic [LOG_W:0]   sweep_q, sweep_d;
  logic [N-1:0]     res_q, res_d;
  logic             res_vld_q, res_vld_d;
  logic [N-1:0]     avg_q, avg_d;
  logic             send_q, send_d;
  logic             done_q, done_d;

  logic             accept;
  logic             sweep_done;
  logic [SumW-1:0]  sum_acc;
  logic [LOG_W:0]   fill_acc;
  logic [N-1:0]     ring_rd;
  logic             ring_clr_en;

  envelope_averager_sample_ring #(
    .N     (N),
    .LOG_W (LOG_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .ptr_i     (wr_ptr_q),
    .wr_en_i   (accept),
    .clr_en_i  (ring_clr_en),
    .wr_data_i (in_data),
    .rd_data_o (ring_rd)
  );

  always_comb begin
    sweep_done = (sweep_q == FillMax);
    // In DONE only a clean ready (no stop) after the sweep starts a new stream.
    accept     = ready && ((state_q != StDone) || (sweep_done && !stop));
    // ring_rd is part of sum_q, so this never underflows.
    sum_acc    = sum_q + SumW'(in_data) - SumW'(ring_rd);
    fill_acc   = (fill_q == FillMax) ? FillMax : fill_q + (LOG_W + 1)'(1);

    state_d     = state_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    sweep_d     = sweep_q;
    res_d       = res_q;
    res_vld_d   = 1'b0;
    ring_clr_en = 1'b0;

    if (accept) begin
      sum_d    = sum_acc;
      wr_ptr_d = wr_ptr_q + LOG_W'(1);
      fill_d   = fill_acc;
      // Stage the result from sum_acc, not sum_q: a stop in the same cycle clears sum_q
      // but the sample's result must still go out.
      if (fill_acc == FillMax) begin
        res_vld_d = 1'b1;
        res_d     = sum_acc[SumW-1:LOG_W];
      end
    end

    unique case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          state_d = (fill_acc == FillMax) ? StRun : StFill;
        end
      end
      StRun: begin
      end
      StDone: begin
        if (accept) begin
          state_d = (fill_acc == FillMax) ? StRun : StFill;
        end else if (!sweep_done) begin
          ring_clr_en = 1'b1;
          wr_ptr_d    = wr_ptr_q + LOG_W'(1);
          sweep_d     = sweep_q + (LOG_W + 1)'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Stop is honoured after the same-cycle sample has been folded in above.
    if (stop && (state_q != StDone)) begin
      state_d  = StDone;
      sum_d    = '0;
      fill_d   = '0;
      wr_ptr_d = '0;
      sweep_d  = '0;
    end

    avg_d  = res_vld_q ? res_q : avg_q;
    send_d = res_vld_q;
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      sweep_q   <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      avg_q     <= '0;
      send_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      sweep_q   <= sweep_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      avg_q     <= avg_d;
      send_q    <= send_d;
      done_q    <= done_d;
    end
  end

  assign avg_data   = avg_q;
  assign send_data  = send_q;
  assign fill_level = fill_q;
  assign done       = done_q;

endmodule

// File: tb/tb_envelope_averager.sv
// Self-checking bench for envelope_averager: a history-window model pushes expected
// averages into a queue as samples are driven; results are popped as send_data pulses.
module tb_envelope_averager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        stop = 1'b0;
  logic [15:0] avg_data;
  logic        send_data;
  logic [3:0]  fill_level;
  logic        done;

  envelope_averager #(
    .N     (16),
    .LOG_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (ready),
    .in_data    (in_data),
    .stop       (stop),
    .avg_data   (avg_data),
    .send_data  (send_data),
    .fill_level (fill_level),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  int          hist[$];
  bit          m_done = 1'b0;
  int          m_sweep = 0;
  logic [15:0] exp_v;
  int          pulses;

  // Called at a negedge: drives one cycle, updates the model, returns at the next negedge.
  task automatic drive(input bit r, input logic [15:0] d, input bit s);
    bit acc;
    int sum;
    ready   = r;
    in_data = d;
    stop    = s;
    acc = r && (!m_done || (m_sweep == 8 && !s));
    if (m_done && !acc && m_sweep < 8) m_sweep++;
    if (acc) begin
      m_done = 1'b0;
      hist.push_back(int'(d));
      if (hist.size() > 8) void'(hist.pop_front());
      if (hist.size() == 8) begin
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        exp_q.push_back(16'(sum / 8));
      end
    end
    if (s && !m_done) begin
      m_done  = 1'b1;
      m_sweep = 0;
      hist.delete();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    ready   = 1'b0;
    in_data = '0;
    stop    = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    hist.delete();
    m_done  = 1'b0;
    m_sweep = 0;
    pulses  = 0;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (avg_data !== 16'd0) $display("FAIL reset avg_data: got %0d, required 0", avg_data);
    else n_pass++;
    n_checks++;
    if (send_data !== 1'b0) $display("FAIL reset send_data: got %b, required 0", send_data);
    else n_pass++;
    n_checks++;
    if (fill_level !== 4'd0) $display("FAIL reset fill_level: got %0d, required 0", fill_level);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset done: got %b, required 0", done);
    else n_pass++;
  endtask

  task automatic test_constant_fill();
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(1'b1, 16'd100, 1'b0);
      else drive(1'b0, 16'd0, 1'b0);
      if (send_data) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL const_fill spurious pulse: avg_data=%0d, required no pulse", avg_data);
        end else begin
          exp_v = exp_q.pop_front();
          pulses++;
          if (avg_data !== exp_v) $display("FAIL const_fill avg: got %0d, required %0d", avg_data, exp_v);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pulses !== 3) $display("FAIL const_fill pulses: got %0d, required 3", pulses);
    else n_pass++;
    n_checks++;
    if (fill_level !== 4'd8) $display("FAIL const_fill fill_level: got %0d, required 8", fill_level);
    else n_pass++;
  endtask

  task automatic test_step();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      if (i < 8) drive(1'b1, 16'd0, 1'b0);
      else if (i < 16) drive(1'b1, 16'd800, 1'b0);
      else drive(1'b0, 16'd0, 1'b0);
      if (send_data) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL step spurious pulse: avg_data=%0d, required no pulse", avg_data);
        end else begin
          exp_v = exp_q.pop_front();
          pulses++;
          if (avg_data !== exp_v) $display("FAIL step avg: got %0d, required %0d", avg_data, exp_v);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pulses !== 9) $display("FAIL step pulses: got %0d, required 9", pulses);
    else n_pass++;
  endtask

  task automatic test_gaps();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drive(1'b1, 16'd100, 1'b0);
      else drive(1'b0, 16'd0, 1'b0);
      if (send_data) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL gaps spurious pulse: avg_data=%0d, required no pulse", avg_data);
        end else begin
          exp_v = exp_q.pop_front();
          pulses++;
          if (avg_data !== exp_v) $display("FAIL gaps avg: got %0d, required %0d", avg_data, exp_v);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pulses !== 3) $display("FAIL gaps pulses: got %0d, required 3", pulses);
    else n_pass++;
  endtask

  task automatic test_max();
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      if (i < 12) drive(1'b1, 16'hFFFF, 1'b0);
      else drive(1'b0, 16'd0, 1'b0);
      if (send_data) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL max spurious pulse: avg_data=%0d, required no pulse", avg_data);
        end else begin
          exp_v = exp_q.pop_front();
          pulses++;
          if (avg_data !== exp_v) $display("FAIL max avg: got %0d, required %0d", avg_data, exp_v);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pulses !== 5) $display("FAIL max pulses: got %0d, required 5", pulses);
    else n_pass++;
    n_checks++;
    if (dut.sum_q !== 19'd524280) $display("FAIL max sum: got %0d, required 524280", dut.sum_q);
    else n_pass++;
  endtask

  task automatic test_stop_restart();
    apply_reset();
    for (int i = 0; i < 26; i++) begin
      if (i < 8) drive(1'b1, 16'd100, 1'b0);
      else if (i == 8) drive(1'b1, 16'd800, 1'b1);
      else if (i == 9) drive(1'b0, 16'd0, 1'b0);
      else if (i < 17) drive(1'b1, 16'd9999, 1'b0);  // ignored during the sweep
      else if (i < 25) drive(1'b1, 16'd50, 1'b0);
      else drive(1'b0, 16'd0, 1'b0);
      if (send_data) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL stop spurious pulse: avg_data=%0d, required no pulse", avg_data);
        end else begin
          exp_v = exp_q.pop_front();
          pulses++;
          if (avg_data !== exp_v) $display("FAIL stop avg: got %0d, required %0d", avg_data, exp_v);
          else n_pass++;
        end
      end
      if (i == 9) begin
        n_checks++;
        if (fill_level !== 4'd0) $display("FAIL stop fill_level: got %0d, required 0", fill_level);
        else n_pass++;
      end
      if (i >= 9 && i < 17) begin
        n_checks++;
        if (done !== 1'b1) $display("FAIL stop done in sweep %0d: got %b, required 1", i, done);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses !== 3) $display("FAIL stop pulses: got %0d, required 3", pulses);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL stop done after restart: got %b, required 0", done);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'd100, 1'b0);
      if (send_data) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL areset spurious pulse: avg_data=%0d, required no pulse", avg_data);
        end else begin
          exp_v = exp_q.pop_front();
          pulses++;
          if (avg_data !== exp_v) $display("FAIL areset avg: got %0d, required %0d", avg_data, exp_v);
          else n_pass++;
        end
      end
    end
    // Assert reset between edges and look before the next posedge.
    #2;
    ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (avg_data !== 16'd0) $display("FAIL areset avg_data: got %0d, required 0", avg_data);
    else n_pass++;
    n_checks++;
    if (send_data !== 1'b0) $display("FAIL areset send_data: got %b, required 0", send_data);
    else n_pass++;
    n_checks++;
    if (fill_level !== 4'd0) $display("FAIL areset fill_level: got %0d, required 0", fill_level);
    else n_pass++;
    @(negedge clk);
    exp_q.delete();
    hist.delete();
    m_done  = 1'b0;
    m_sweep = 0;
    pulses  = 0;
    rst_n   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 16'd100, 1'b0);
      else drive(1'b0, 16'd0, 1'b0);
      if (i == 0) begin
        n_checks++;
        if (fill_level !== 4'd1) $display("FAIL areset refill: got %0d, required 1", fill_level);
        else n_pass++;
      end
      if (send_data) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL areset refill spurious pulse: avg_data=%0d, required no pulse", avg_data);
        end else begin
          exp_v = exp_q.pop_front();
          pulses++;
          if (avg_data !== exp_v) $display("FAIL areset refill avg: got %0d, required %0d", avg_data, exp_v);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pulses !== 1) $display("FAIL areset refill pulses: got %0d, required 1", pulses);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_constant_fill();
    test_step();
    test_gaps();
    test_max();
    test_stop_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/envelope_averager.md
Name: envelope_averager

Overview:
- Downstream consumer of the rectifier stage.
- Takes the rectified magnitude samples and computes a 2^LOG_W-point moving average, producing a smoothed envelope for the output/logging stage.
- Accepts one sample per cycle on the same ready/data/stop convention the rectifier uses, and emits one averaged sample per accepted input once the window is full.

Parameters:
- N, 16, sample width; input is an unsigned magnitude.
- LOG_W, 3, log2 of window length; W = 2^LOG_W = 8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ready  input  1  upstream sample valid this cycle.
- in_data  input  N  rectified sample (unsigned).
- stop  input  1  upstream end-of-stream marker.
- avg_data  output  N  moving-average result.
- send_data  output  1  avg_data valid; one-cycle pulse per result.
- fill_level  output  LOG_W+1  number of samples currently in the window (0..W).
- done  output  1  end-of-stream acknowledged; held high in DONE.

Behaviour:
- Reset (async, rst_n=0): all outputs and state are zeroed.
  - avg_data=0, send_data=0, fill_level=0, done=0.
  - sum=0, wr_ptr=0, state=IDLE.
  - Ring contents are zeroed in place by reset, so no flush pass is needed.
- Accept: a sample is accepted on a rising edge with ready=1 while state is not DONE, or on the first ready=1 in DONE (see DONE below).
- Datapath per accept (edge k):
  - sum <= sum + in_data - ring[wr_ptr].
  - ring[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr+1, wrapping modulo W.
  - fill_level saturates at W.
- Widths and arithmetic:
  - sum is N+LOG_W bits, unsigned; no overflow is possible.
  - The evicted value is 0 during fill, because the ring is zeroed by reset and on stream restart.
- Output stage, one-cycle latency: at edge k+1, avg_data <= sum[N+LOG_W-1:LOG_W] (truncating shift, no rounding).
  - send_data=1 for exactly that cycle, only if fill_level had reached W by the accept at edge k.
  - The first send_data follows the W-th accepted sample.
- ready=0: no accept; sum, ring, pointer and fill are held; send_data=0 next cycle.
- FSM states:
  - IDLE: fill_level=0. ready → FILL.
  - FILL: 0<fill_level<W. Accept W-th sample → RUN.
  - RUN: window full; every accept yields one result. stop → DONE.
  - DONE: done=1; sum, fill_level, wr_ptr and ring are cleared.
- stop handling:
  - stop is sampled in FILL or RUN (and in IDLE, where it goes directly to DONE).
  - ready and stop high together: the sample is processed first, its result is emitted if qualified, then the FSM enters DONE.
  - Ring clearing in DONE takes W cycles via wr_ptr sweep; done stays high throughout.
- Leaving DONE:
  - A ready=1 with stop=0 after the clear sweep has completed starts a new stream in FILL.
  - ready during the sweep is ignored; upstream must wait for done plus W cycles. This constraint is part of the interface.
- Reset mid-operation: immediate async return to the reset state; any in-flight result is dropped.

Decomposition:
- Shared package: state enum (IDLE, FILL, RUN, DONE), default LOG_W, and a SUM_W = N+LOG_W function/constant. The rectifier and downstream stages reuse these.
- One sub-module, sample_ring: W×N register ring with read-before-write at wr_ptr and synchronous clear-sweep support.
- The FSM, accumulator and output register stay in envelope_averager.

Test Plan:
- Constant fill: reset, then 10 accepts of in_data=100 on consecutive cycles → send_data is 0 for the first 7 results, then avg_data=100 on cycles after accepts 8, 9 and 10; fill_level=8.
- Step response: 8×0 then 8×800 → after the first 8 accepts, avg_data=0; then avg_data = 100, 200, ..., 800 on successive send_data pulses.
- Gaps: the same stream as the constant-fill case with ready=0 on alternate cycles → identical avg_data sequence, send_data pulses only after accepting edges, no spurious pulses.
- Max value: 12×65535 → avg_data=65535, sum=524280, no wrap.
- Stop with sample: in RUN, ready=1 and stop=1 together with in_data=800 over a window of 100s → one result avg_data=187, then done=1; fill_level=0.
  - After the W-cycle sweep, a new stream of 8×50 → first result 50, with no contamination from old data.
- Async reset mid-RUN: drop rst_n between clock edges → outputs go to 0 immediately, without waiting for a clock edge.
  - On release, the FILL sequence restarts from the count of zero.
